// File: rtl/int_mult_pipe_if.sv
`default_nettype none
// =============================================================================
// Module   : int_mult_pipe_if
// Brief    : Operand/result handshake bundle for the pipelined multiplier.
// Revision : 1.0 - initial release
// =============================================================================
interface int_mult_pipe_if #(
   parameter int DATA_W = 60,
   parameter int TAG_W  = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_a;
   logic [DATA_W-1:0]   in_b;
   logic [1:0]          in_mode;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [2*DATA_W-1:0] out_p;
   logic [TAG_W-1:0]    out_tag;
   logic [1:0]          inflight;

   modport slave (
      input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_p, out_tag, inflight
   );

   modport master (
      output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_p, out_tag, inflight
   );
endinterface
`default_nettype wire

// File: rtl/int_mult_pipe.sv
`default_nettype none
// =============================================================================
// Module   : int_mult_pipe
// Brief    : 3-stage chunked unsigned multiplier (DSP, CSA, CPA) with
//            per-stage valid/ready flow control and bubble collapse.
// Revision : 1.0 - initial release
// =============================================================================
module int_mult_pipe #(
   parameter int DATA_W  = 60,
   parameter int CHUNK_W = 16,
   parameter int TAG_W   = 8
) (
   input  wire logic      clk,
   input  wire logic      reset,
   int_mult_pipe_if.slave bus
);
   localparam int N  = (DATA_W + CHUNK_W - 1) / CHUNK_W;
   localparam int NW = N * CHUNK_W;
   localparam int XW = 2 * NW;
   localparam int PW = 2 * DATA_W;
   localparam int NP = N * N;
   localparam int CW2 = 2 * CHUNK_W;

   logic [NW-1:0]    w_a_pad;
   logic [NW-1:0]    w_b_pad;
   logic [PW-1:0]    w_pp [NP];
   logic             w_adv1;
   logic             w_adv2;
   logic             w_adv3;

   logic             r_v1;
   logic [PW-1:0]    r_pp1 [NP];
   logic [1:0]       r_mode1;
   logic [TAG_W-1:0] r_tag1;

   logic             r_v2;
   logic [PW-1:0]    r_s2;
   logic [PW-1:0]    r_c2;
   logic [1:0]       r_mode2;
   logic [TAG_W-1:0] r_tag2;

   logic             r_v3;
   logic [PW-1:0]    r_p3;
   logic [TAG_W-1:0] r_tag3;

   logic [PW-1:0]    w_sum;
   logic [PW-1:0]    w_car;
   logic [PW-1:0]    w_sum_nx;
   logic [PW-1:0]    w_p;
   logic [PW-1:0]    w_fmt;

   // Ready chain depends only on stage occupancy and out_ready.
   assign w_adv3       = ~r_v3 | bus.out_ready;
   assign w_adv2       = ~r_v2 | w_adv3;
   assign w_adv1       = ~r_v1 | w_adv2;
   assign bus.in_ready = w_adv1;

   assign w_a_pad = NW'(bus.in_a);
   assign w_b_pad = (bus.in_mode == 2'd3) ? NW'(bus.in_a) : NW'(bus.in_b);

   // Each shifted chunk product is bounded by the full product, so PW bits hold it exactly.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_row
         for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [CW2-1:0] w_prod;
            assign w_prod = CW2'(w_a_pad[gi*CHUNK_W +: CHUNK_W]) *
                            CW2'(w_b_pad[gj*CHUNK_W +: CHUNK_W]);
            assign w_pp[gi*N+gj] = PW'(XW'(w_prod) << ((gi + gj) * CHUNK_W));
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1    <= 1'b0;
         r_mode1 <= '0;
         r_tag1  <= '0;
         for (int k = 0; k < NP; k++) r_pp1[k] <= '0;
      end else if (w_adv1) begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_mode1 <= bus.in_mode;
            r_tag1  <= bus.in_tag;
            for (int k = 0; k < NP; k++) r_pp1[k] <= w_pp[k];
         end
      end
   end

   // Linear chain of 3:2 compressors; with one product it yields (product, 0).
   always_comb begin
      w_sum    = '0;
      w_car    = '0;
      w_sum_nx = '0;
      for (int k = 0; k < NP; k++) begin
         w_sum_nx = w_sum ^ w_car ^ r_pp1[k];
         w_car    = ((w_sum & w_car) | (w_sum & r_pp1[k]) | (w_car & r_pp1[k])) << 1;
         w_sum    = w_sum_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v2    <= 1'b0;
         r_s2    <= '0;
         r_c2    <= '0;
         r_mode2 <= '0;
         r_tag2  <= '0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2    <= w_sum;
            r_c2    <= w_car;
            r_mode2 <= r_mode1;
            r_tag2  <= r_tag1;
         end
      end
   end

   assign w_p = r_c2 + r_s2;

   always_comb begin
      w_fmt = w_p;
      case (r_mode2)
         2'd1:    w_fmt = PW'(w_p[DATA_W-1:0]);
         2'd2:    w_fmt = PW'(w_p[PW-1:DATA_W]);
         default: w_fmt = w_p;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v3   <= 1'b0;
         r_p3   <= '0;
         r_tag3 <= '0;
      end else if (w_adv3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_p3   <= w_fmt;
            r_tag3 <= r_tag2;
         end
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.out_p     = r_p3;
   assign bus.out_tag   = r_tag3;
   assign bus.inflight  = 2'(r_v1) + 2'(r_v2) + 2'(r_v3);

endmodule
`default_nettype wire

// File: tb/tb_int_mult_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_int_mult_pipe
// Brief    : Self-checking bench: vector table, directed flow-control cases,
//            and randomized traffic against an arithmetic reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_int_mult_pipe #(
   parameter int DATA_W  = 60,
   parameter int CHUNK_W = 16,
   parameter int TAG_W   = 8
);
   localparam int PW     = 2 * DATA_W;
   localparam int N_RAND = 10000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int_mult_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   int_mult_pipe #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [1:0]        mode;
      logic [TAG_W-1:0]  tag;
      logic [PW-1:0]     exp;
   } vec_t;

   typedef struct {
      logic [PW-1:0]    p;
      logic [TAG_W-1:0] tag;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;
   exp_t sb_q[$];
   exp_t sb_e;
   logic held = 1'b0;
   logic [PW-1:0]    held_p;
   logic [TAG_W-1:0] held_tag;
   bit   rand_done = 1'b0;

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain full-width arithmetic on the operands.
   function automatic logic [PW-1:0] ref_p(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                           input logic [1:0] m);
      logic [PW-1:0] full;
      full = PW'(a) * PW'((m == 2'd3) ? a : b);
      case (m)
         2'd1:    return full % (PW'(1) << DATA_W);
         2'd2:    return full >> DATA_W;
         default: return full;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] rnd_opnd();
      logic [95:0] r;
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         default: begin
            r = {$urandom(), $urandom(), $urandom()};
            return DATA_W'(r);
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [1:0] m, input logic [TAG_W-1:0] t);
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = m;
      bus.in_tag   = t;
      for (int w = 0; w < 1000 && !acc; w++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", 1'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      bus.out_ready = 1'b1;
      while ((sb_q.size() != 0 || bus.out_valid) && w < 300) begin
         tick();
         w++;
      end
      chk("drain_empty", sb_q.size(), 0);
   endtask

   task automatic run_single(input string nm, input vec_t v);
      bus.out_ready = 1'b1;
      send_op(v.a, v.b, v.mode, v.tag);
      chk({nm, "_v_c1"}, 1'(bus.out_valid), 0);
      tick();
      chk({nm, "_v_c2"}, 1'(bus.out_valid), 0);
      tick();
      chk({nm, "_v_c3"}, 1'(bus.out_valid), 1);
      chk({nm, "_p"}, bus.out_p, v.exp);
      chk({nm, "_tag"}, PW'(bus.out_tag), PW'(v.tag));
      tick();
   endtask

   // Scoreboard: records accepts, checks every emission and output stability under stall.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", 1'(bus.out_valid), 1);
            chk("hold_p", bus.out_p, held_p);
            chk("hold_tag", PW'(bus.out_tag), PW'(held_tag));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 1'(bus.out_valid), 0);
            end else begin
               sb_e = sb_q.pop_front();
               chk("sb_p", bus.out_p, sb_e.p);
               chk("sb_tag", PW'(bus.out_tag), PW'(sb_e.tag));
               n_out++;
            end
         end
         held     = bus.out_valid && !bus.out_ready;
         held_p   = bus.out_p;
         held_tag = bus.out_tag;
         if (bus.in_valid && bus.in_ready)
            sb_q.push_back('{ref_p(bus.in_a, bus.in_b, bus.in_mode), bus.in_tag});
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t              tbl[8];
      vec_t              sv;
      logic [DATA_W-1:0] maxv;
      logic [DATA_W-1:0] sa;
      logic [DATA_W-1:0] sb;
      logic [PW-1:0]     one;
      logic [PW-1:0]     sq_max;
      logic [PW-1:0]     sweep_exp[4];
      int                n0;

      maxv   = '1;
      one    = PW'(1);
      sq_max = -(one << (DATA_W + 1)) + one;
      tbl[0] = '{maxv, maxv, 2'd0, TAG_W'(8'h5A), sq_max};
      tbl[1] = '{DATA_W'(3), DATA_W'(5), 2'd0, TAG_W'(8'h01), PW'(15)};
      tbl[2] = '{maxv, maxv, 2'd1, TAG_W'(8'h02), one};
      tbl[3] = '{maxv, maxv, 2'd2, TAG_W'(8'h03), PW'(maxv) - one};
      tbl[4] = '{maxv, DATA_W'(1), 2'd3, TAG_W'(8'h04), sq_max};
      tbl[5] = '{'0, maxv, 2'd0, TAG_W'(8'h05), '0};
      tbl[6] = '{maxv, DATA_W'(1), 2'd0, TAG_W'(8'h06), PW'(maxv)};
      tbl[7] = '{DATA_W'(7), DATA_W'(9), 2'd3, TAG_W'(8'h07), PW'(49)};

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_mode   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      repeat (3) tick();
      chk("rst_out_valid", 1'(bus.out_valid), 0);
      chk("rst_inflight", PW'(bus.inflight), 0);
      chk("rst_out_p", bus.out_p, 0);
      chk("rst_out_tag", PW'(bus.out_tag), 0);
      reset = 1'b0;
      tick();
      chk("rst_in_ready", 1'(bus.in_ready), 1);

      for (int i = 0; i < 8; i++) run_single($sformatf("tbl%0d", i), tbl[i]);

      // Mode sweep: four back-to-back ops must emerge on consecutive cycles.
      sa = DATA_W'(64'h0123456789ABCDEF);
      sb = DATA_W'(64'h0FEDCBA987654321);
      for (int m = 0; m < 4; m++) sweep_exp[m] = ref_p(sa, sb, 2'(m));
      bus.out_ready = 1'b1;
      fork
         begin
            for (int m = 0; m < 4; m++) send_op(sa, sb, 2'(m), TAG_W'(8'h10 + m));
         end
         begin
            repeat (3) tick();
            for (int m = 0; m < 4; m++) begin
               chk($sformatf("sweep%0d_valid", m), 1'(bus.out_valid), 1);
               chk($sformatf("sweep%0d_p", m), bus.out_p, sweep_exp[m]);
               tick();
            end
         end
      join
      drain();

      // Backpressure: five ops offered into a stalled pipe.
      n0 = n_out;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++) send_op(rnd_opnd(), rnd_opnd(), 2'(k % 4), TAG_W'(8'h20 + k));
         end
         begin
            repeat (8) tick();
            chk("bp_inflight", PW'(bus.inflight), 3);
            chk("bp_in_ready", 1'(bus.in_ready), 0);
            chk("bp_out_valid", 1'(bus.out_valid), 1);
            chk("bp_out_tag", PW'(bus.out_tag), PW'(TAG_W'(8'h20)));
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out - n0, 5);

      // Bubble collapse: stall lands after op0 reaches S3, empty S1/S2 still fill.
      bus.out_ready = 1'b1;
      send_op(DATA_W'(11), DATA_W'(13), 2'd0, TAG_W'(8'hB0));
      tick();
      tick();
      bus.out_ready = 1'b0;
      send_op(DATA_W'(2), DATA_W'(3), 2'd1, TAG_W'(8'hB1));
      send_op(DATA_W'(4), DATA_W'(5), 2'd2, TAG_W'(8'hB2));
      chk("bub_inflight", PW'(bus.inflight), 3);
      chk("bub_in_ready", 1'(bus.in_ready), 0);
      chk("bub_out_tag", PW'(bus.out_tag), PW'(TAG_W'(8'hB0)));
      chk("bub_out_p", bus.out_p, PW'(143));
      drain();

      // Reset with two ops in flight.
      bus.out_ready = 1'b0;
      send_op(DATA_W'(6), DATA_W'(7), 2'd0, TAG_W'(8'hC1));
      send_op(DATA_W'(8), DATA_W'(9), 2'd0, TAG_W'(8'hC2));
      chk("mid_inflight", PW'(bus.inflight), 2);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 1'(bus.out_valid), 0);
      chk("mid_rst_inflight", PW'(bus.inflight), 0);
      chk("mid_rst_p", bus.out_p, 0);
      tick();
      tick();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) tick();
      chk("post_rst_valid", 1'(bus.out_valid), 0);
      sv = '{DATA_W'(3), DATA_W'(5), 2'd0, TAG_W'(8'hD0), PW'(15)};
      run_single("post_rst", sv);
      drain();

      // Randomized traffic with random valid gaps and random out_ready.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < N_RAND; i++) begin
               if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
               send_op(rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), TAG_W'($urandom()));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      drain();
      chk("rand_count", n_out - n0, N_RAND);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
